// File: rtl/patch_request_master_if.sv
// Patch-store request bus between the request master and the patching responder.
// The master drives request/read_write/address/activation_in; the responder answers with valid/error/rd_data.
interface patch_request_master_if #(
    parameter int N      = 16,
    parameter int ADDR_W = 21
);
    logic              request;
    logic              read_write;
    logic [ADDR_W-1:0] address;
    logic [N-1:0]      activation_in;
    logic              valid;
    logic              error;
    logic [N-1:0]      rd_data;

    modport master (
        output request,
        output read_write,
        output address,
        output activation_in,
        input  valid,
        input  error,
        input  rd_data
    );

    modport slave (
        input  request,
        input  read_write,
        input  address,
        input  activation_in,
        output valid,
        output error,
        output rd_data
    );
endinterface

// File: rtl/patch_request_master.sv
// Buffers host patch commands in a FIFO and issues them one at a time to the patch responder.
// Write read-back verification is built only when PATCH_MASTER_VERIFY_EN is defined.
module patch_request_master #(
    parameter int N          = 16,
    parameter int ADDR_W     = 21,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_address,
    input  logic [N-1:0]           cmd_data,
    patch_request_master_if.master bus,
    output logic                   rsp_valid,
    output logic [N-1:0]           rsp_data,
    output logic [1:0]             rsp_status,
    output logic                   busy,
    output logic [7:0]             err_count
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + N;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       TMO_LAST   = 8'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_VMM = 2'b11;

`ifdef PATCH_MASTER_VERIFY_EN
    localparam logic VERIFY_ON = 1'b1;
`else
    localparam logic VERIFY_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VREQ  = 3'd3,
        S_VWAIT = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_s;
    logic               pop_s;

    state_t             state_r;
    logic               request_r;
    logic               read_write_r;
    logic [ADDR_W-1:0]  address_r;
    logic [N-1:0]       activation_r;
    logic [7:0]         tmo_cnt_r;
    logic               rsp_valid_r;
    logic [N-1:0]       rsp_data_r;
    logic [1:0]         rsp_status_r;
    logic [7:0]         err_count_r;

    logic               done_s;
    logic [1:0]         done_status_s;
    logic [N-1:0]       done_data_s;
    logic               to_verify_s;

    assign cmd_ready = (count_r != FULL_COUNT);
    assign push_s    = cmd_valid && cmd_ready;
    // Only an idle FSM takes the head, so a same-cycle push into an empty FIFO is never popped early.
    assign pop_s     = (state_r == S_IDLE) && (count_r != {CNT_W{1'b0}});
    assign busy      = (count_r != {CNT_W{1'b0}}) || (state_r != S_IDLE);

    assign bus.request       = request_r;
    assign bus.read_write    = read_write_r;
    assign bus.address       = address_r;
    assign bus.activation_in = activation_r;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_data          = rsp_data_r;
    assign rsp_status        = rsp_status_r;
    assign err_count         = err_count_r;

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= {cmd_write, cmd_address, cmd_data};
    end

    // Outcome of the current wait cycle; error outranks valid, both outrank the timeout
    always_comb begin
        done_s        = 1'b0;
        done_status_s = ST_OK;
        done_data_s   = {N{1'b0}};
        to_verify_s   = 1'b0;
        if ((state_r == S_WAIT) || (state_r == S_VWAIT)) begin
            if (bus.error) begin
                done_s        = 1'b1;
                done_status_s = ST_ERR;
            end else if (bus.valid) begin
                if (state_r == S_VWAIT) begin
                    done_s        = 1'b1;
                    done_status_s = (bus.rd_data == activation_r) ? ST_OK : ST_VMM;
                    done_data_s   = bus.rd_data;
                end else if (read_write_r && VERIFY_ON) begin
                    to_verify_s = 1'b1;
                end else begin
                    done_s      = 1'b1;
                    done_data_s = read_write_r ? activation_r : bus.rd_data;
                end
            end else if (tmo_cnt_r == TMO_LAST) begin
                done_s        = 1'b1;
                done_status_s = ST_TMO;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            request_r    <= 1'b0;
            read_write_r <= 1'b0;
            address_r    <= {ADDR_W{1'b0}};
            activation_r <= {N{1'b0}};
            tmo_cnt_r    <= 8'd0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {N{1'b0}};
            rsp_status_r <= ST_OK;
            err_count_r  <= 8'd0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        {read_write_r, address_r, activation_r} <= mem_r[rd_ptr_r];
                        request_r <= 1'b1;
                        state_r   <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt_r <= 8'd0;
                    state_r   <= S_WAIT;
                end
`ifdef PATCH_MASTER_VERIFY_EN
                // Read-back request: request was dropped for one cycle so read_write never changes under it
                S_VREQ: begin
                    request_r <= 1'b1;
                    tmo_cnt_r <= 8'd0;
                    state_r   <= S_VWAIT;
                end
`endif
                S_WAIT, S_VWAIT: begin
                    if (done_s) begin
                        request_r    <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        rsp_status_r <= done_status_s;
                        rsp_data_r   <= done_data_s;
                        state_r      <= S_RESP;
                    end else if (to_verify_s) begin
                        request_r    <= 1'b0;
                        read_write_r <= 1'b0;
                        state_r      <= S_VREQ;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                S_RESP: begin
                    if ((rsp_status_r != ST_OK) && (err_count_r != 8'hFF)) begin
                        err_count_r <= err_count_r + 8'd1;
                    end
                    state_r <= S_IDLE;
                end
                default: begin
                    request_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
